multibyte_add_seq: RTL

MULTIBYTE_ADD_SEQ -- requirements
Module: multibyte_add_seq

---
 rtl/multibyte_add_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/multibyte_add_seq.sv
// Byte-serial adder: one 8-bit slice time-shared over NBYTES bytes, LSB byte first.
// Latency: start accepted at edge T -> done high in the cycle after edge T+NBYTES; busy for NBYTES+1 cycles.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
//
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   start             - request pulse, accepted only in IDLE
//   a, b, cin         - operands and carry-in, captured on the accepting edge
//   sub               - subtract request (only when SUB_EN is defined)
//   busy, done        - busy while not IDLE; done is a one-cycle result-valid pulse
//   result, cout      - {cout,result} = A + B + cin, held until the next accepted start
// Optional feature macro: SUB_EN (adds port sub; sub=1 computes A - B, cout=1 means no borrow).

module multibyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
`ifdef SUB_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_res;
    logic            r_carry;
    logic            r_cout;
    logic [IW-1:0]   r_idx;
`ifdef SUB_EN
    logic            r_sub;
`endif

    logic [7:0]      w_a8;
    logic [7:0]      w_b8;
    logic [8:0]      w_sum9;
    logic            w_last;
    logic            w_busy;
    logic            w_done;

    // The single shared 8-bit slice; operand bytes selected by the running index.
    assign w_a8 = r_a[{r_idx, 3'b000} +: 8];
`ifdef SUB_EN
    // Subtraction as A + ~B + 1: invert the B byte ahead of the slice.
    assign w_b8 = r_sub ? ~r_b[{r_idx, 3'b000} +: 8] : r_b[{r_idx, 3'b000} +: 8];
`else
    assign w_b8 = r_b[{r_idx, 3'b000} +: 8];
`endif
    assign w_sum9 = {1'b0, w_a8} + {1'b0, w_b8} + {8'd0, r_carry};
    assign w_last = (r_idx == IW'(NBYTES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
`ifdef SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_idx <= '0;
`ifdef SUB_EN
                        r_sub   <= sub;
                        r_carry <= sub ? 1'b1 : cin;
`else
                        r_carry <= cin;
`endif
                    end
                end
                S_RUN: begin
                    // Only the current byte is written; later bytes keep their old value.
                    r_res[{r_idx, 3'b000} +: 8] <= w_sum9[7:0];
                    r_carry                     <= w_sum9[8];
                    r_idx                       <= r_idx + 1'b1;
                    if (w_last) begin
                        r_cout <= w_sum9[8];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = w_busy;
    assign done   = w_done;
    assign result = r_res;
    assign cout   = r_cout;

endmodule
